// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, ALU function-select codes,
// and the small enums used by the ID/EX stage and its forwarding muxes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef enum logic [3:0] {
    GS_ADD  = 4'b0000,
    GS_SLT  = 4'b0010,
    GS_SLTU = 4'b0011,
    GS_AND  = 4'b0100,
    GS_OR   = 4'b0101,
    GS_NOR  = 4'b0110,
    GS_XOR  = 4'b0111,
    GS_SUB  = 4'b1000
  } gs_e;

  // Operand source chosen by a forwarding mux.
  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXM,
    FWD_WB
  } fwd_sel_e;

  // What the ID/EX stage registers do on the coming edge (reset aside).
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_CAPTURE
  } stage_act_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Per-operand forwarding mux: EX/MEM result beats MEM/WB data, which beats
// the register-file value captured in ID/EX. x0 is never forwarded.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned RA_W = riscv_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_NONE;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      sel = FWD_EXM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: operand forwarding,
// load-use bubble insertion, flush and hold. Optional perf counters under
// ID_EX_PERF_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_gs,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            hold,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [3:0]      ex_gs,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_store_data
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic            valid_q,     valid_d;
  logic [RA_W-1:0] rs1_q,       rs1_d;
  logic [RA_W-1:0] rs2_q,       rs2_d;
  logic [RA_W-1:0] rd_q,        rd_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic            use_imm_q,   use_imm_d;
  logic [3:0]      gs_q,        gs_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;

  logic            load_use;
  stage_act_e      act;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
               ((rd_q == id_rs1) || (rd_q == id_rs2));
  end

  always_comb begin
    if (hold) begin
      act = ACT_HOLD;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_CAPTURE;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    gs_d        = gs_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    unique case (act)
      ACT_HOLD: begin
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      ACT_CAPTURE: begin
        valid_d     = id_valid;
        rs1_d       = id_rs1;
        rs2_d       = id_rs2;
        rd_d        = id_rd;
        rs1_data_d  = id_rs1_data;
        rs2_data_d  = id_rs2_data;
        imm_d       = id_imm;
        use_imm_d   = id_use_imm;
        gs_d        = id_gs;
        reg_write_d = id_reg_write & id_valid;
        mem_read_d  = id_mem_read  & id_valid;
        mem_write_d = id_mem_write & id_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      gs_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      gs_q        <= gs_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  forward_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs            (rs1_q),
    .reg_data      (rs1_data_q),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rs1)
  );

  forward_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs            (rs2_q),
    .reg_data      (rs2_data_q),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rs2)
  );

  // Operands are forced to zero while reset is asserted, even before the
  // first reset edge has cleared the registers.
  always_comb begin
    id_stall      = (load_use | hold) & ~rst;
    ex_A          = rst ? '0 : fwd_rs1;
    ex_B          = rst ? '0 : (use_imm_q ? imm_q : fwd_rs2);
    ex_store_data = rst ? '0 : fwd_rs2;
    ex_valid      = valid_q;
    ex_gs         = gs_q;
    ex_rd         = rd_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (act == ACT_BUBBLE) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (act == ACT_FLUSH) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    bubble_cnt = bubble_cnt_q;
    flush_cnt  = flush_cnt_q;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding vector table, hand-written
// load-use / flush / hold / reset sequences, and randomized cycles.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_use_imm;
  logic [3:0]      id_gs;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic [RA_W-1:0] exm_rd;
  logic            exm_reg_write;
  logic [XLEN-1:0] exm_result;
  logic [RA_W-1:0] wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;
  logic            flush, hold;
  logic            id_stall, ex_valid;
  logic [XLEN-1:0] ex_A, ex_B, ex_store_data;
  logic [3:0]      ex_gs;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
`ifdef ID_EX_PERF_EN
  logic [31:0]     bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_gs(id_gs),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .flush(flush), .hold(hold), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_A(ex_A), .ex_B(ex_B), .ex_gs(ex_gs), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [3:0]  gs;
    logic        rw, mr, mw;
    bit          data_known;
  } slot_t;

  slot_t       m;
  logic [31:0] m_bub, m_fl;

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs != 5'd0 && exm_reg_write && exm_rd == rs) return exm_result;
    if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_data;
    return d;
  endfunction

  function automatic bit m_load_use();
    return m.valid && m.mr && (m.rd != 5'd0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  task automatic m_reset();
    m = '{default: '0};
    m.data_known = 1'b1;
    m_bub = '0;
    m_fl  = '0;
  endtask

  task automatic check_now();
    bit lu;
    lu = m_load_use();
    chk("id_stall",     32'(id_stall),     32'((lu || hold) && !rst));
    chk("ex_valid",     32'(ex_valid),     32'(m.valid));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
    chk("ex_mem_read",  32'(ex_mem_read),  32'(m.mr));
    chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
    if (rst) begin
      chk("ex_A_rst",  ex_A,          32'd0);
      chk("ex_B_rst",  ex_B,          32'd0);
      chk("ex_sd_rst", ex_store_data, 32'd0);
    end else if (m.data_known) begin
      chk("ex_A",  ex_A,          m_fwd(m.rs1, m.d1));
      chk("ex_B",  ex_B,          m.use_imm ? m.imm : m_fwd(m.rs2, m.d2));
      chk("ex_sd", ex_store_data, m_fwd(m.rs2, m.d2));
      chk("ex_gs", 32'(ex_gs),    32'(m.gs));
      chk("ex_rd", 32'(ex_rd),    32'(m.rd));
    end
`ifdef ID_EX_PERF_EN
    chk("bubble_cnt", bubble_cnt, m_bub);
    chk("flush_cnt",  flush_cnt,  m_fl);
`endif
  endtask

  // Called at posedge+1: check mid-cycle, take the edge, advance the model.
  task automatic tick();
    bit lu;
    #4;
    check_now();
    lu = m_load_use();
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (hold) begin
    end else if (flush || lu) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      m.data_known = 1'b0;
      if (flush) m_fl = m_fl + 32'd1;
      else       m_bub = m_bub + 32'd1;
    end else begin
      m.valid = id_valid;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      m.use_imm = id_use_imm; m.gs = id_gs;
      m.rw = id_reg_write & id_valid;
      m.mr = id_mem_read & id_valid;
      m.mw = id_mem_write & id_valid;
      m.data_known = 1'b1;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui, input logic [3:0] gs,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
    id_gs = gs; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [4:0] erd, input logic ew, input logic [31:0] er,
                         input logic [4:0] wrd, input logic ww, input logic [31:0] wd);
    exm_rd = erd; exm_reg_write = ew; exm_result = er;
    wb_rd = wrd; wb_reg_write = ww; wb_data = wd;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [4:0]  erd;  logic ew; logic [31:0] er;
    logic [4:0]  wrd;  logic ww; logic [31:0] wd;
    logic [31:0] exp_a, exp_b, exp_sd;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] fl0, bub0;

  initial begin
    vecs[0] = '{5'd5, 5'd6, 32'hA5, 32'hB6, 32'h100, 1'b0, 5'd5, 1'b1, 32'h11, 5'd5, 1'b1, 32'h22,
                32'h11, 32'hB6, 32'hB6};
    vecs[1] = '{5'd5, 5'd6, 32'hA5, 32'hB6, 32'h100, 1'b0, 5'd5, 1'b0, 32'h11, 5'd5, 1'b1, 32'h22,
                32'h22, 32'hB6, 32'hB6};
    vecs[2] = '{5'd3, 5'd0, 32'h33, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h44,
                32'h33, 32'h0, 32'h0};
    vecs[3] = '{5'd2, 5'd4, 32'h7, 32'h9, 32'hFFFF_FFF0, 1'b1, 5'd4, 1'b1, 32'h1234, 5'd2, 1'b1, 32'h55,
                32'h55, 32'hFFFF_FFF0, 32'h1234};
    vecs[4] = '{5'd9, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 5'd8, 1'b1, 32'h88, 5'd9, 1'b1, 32'hCAFE,
                32'hCAFE, 32'hCAFE, 32'hCAFE};
    vecs[5] = '{5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 5'd11, 1'b0, 32'h99, 5'd10, 1'b0, 32'h77,
                32'hDEAD, 32'hBEEF, 32'hBEEF};

    // Reset held two cycles with a valid instruction presented.
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h30, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    m_reset();
    tick();
    tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_A",     ex_A,          32'd0);
    chk("rst_ex_B",     ex_B,          32'd0);
    chk("rst_id_stall", 32'(id_stall), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_capture_valid", 32'(ex_valid), 32'd1);
    chk("first_capture_A",     ex_A,          32'h10);

    // Forwarding vector table.
    for (int i = 0; i < 6; i++) begin
      set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_id(1'b1, vecs[i].rs1, vecs[i].rs2, 5'd1, vecs[i].d1, vecs[i].d2, vecs[i].imm,
             vecs[i].use_imm, 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      set_fwd(vecs[i].erd, vecs[i].ew, vecs[i].er, vecs[i].wrd, vecs[i].ww, vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_A", i),  ex_A,          vecs[i].exp_a);
      chk($sformatf("vec%0d_B", i),  ex_B,          vecs[i].exp_b);
      chk($sformatf("vec%0d_sd", i), ex_store_data, vecs[i].exp_sd);
    end

    // Load-use: lw x7 in EX, add reading x7 in ID.
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h100, 32'h200, 32'h8, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd2, 5'd8, 32'h5, 32'h6, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 32'(id_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid),     32'd0);
    chk("lu_bubble_rw",    32'(ex_reg_write), 32'd0);
    chk("lu_bubble_mr",    32'(ex_mem_read),  32'd0);
    chk("lu_bubble_mw",    32'(ex_mem_write), 32'd0);
    chk("lu_stall_clear",  32'(id_stall),     32'd0);
    set_fwd(5'd7, 1'b1, 32'h108, 5'd0, 1'b0, 32'h0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 32'h7777);
    #1;
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_A_wb",  ex_A,          32'h7777);

    // Flush together with a load-use condition.
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h100, 32'h200, 32'h8, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    fl0 = m_fl; bub0 = m_bub;
    set_id(1'b1, 5'd7, 5'd2, 5'd8, 32'h5, 32'h6, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_lu_valid", 32'(ex_valid),     32'd0);
    chk("flush_lu_rw",    32'(ex_reg_write), 32'd0);
`ifdef ID_EX_PERF_EN
    chk("flush_lu_flush_cnt",  flush_cnt,  fl0 + 32'd1);
    chk("flush_lu_bubble_cnt", bubble_cnt, bub0);
`endif

    // Hold for three cycles with changing decode input, then flush under hold.
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'hABC, 32'hDEF, 32'h0, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(12 + i), 5'(20 + i), 5'(i + 1), 32'(i * 3 + 1), 32'(i * 5 + 2), 32'h4,
             1'b1, 4'(i), 1'b0, 1'b1, 1'b1);
      #1;
      chk($sformatf("hold%0d_A", i),     ex_A,          32'hABC);
      chk($sformatf("hold%0d_gs", i),    32'(ex_gs),    32'd7);
      chk($sformatf("hold%0d_rd", i),    32'(ex_rd),    32'd9);
      chk($sformatf("hold%0d_stall", i), 32'(id_stall), 32'd1);
      tick();
    end
    flush = 1'b1;
    tick();
    chk("hold_flush_valid", 32'(ex_valid),     32'd1);
    chk("hold_flush_rw",    32'(ex_reg_write), 32'd1);
    chk("hold_flush_A",     ex_A,              32'hABC);
    hold = 1'b0; flush = 1'b0;

    // Randomized cycles against the model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      set_fwd(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      tick();
    end
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the execute ALU.
- Registers decoded operands and control, resolves operand forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Drives the ALU operands A/B and the 4-bit function select GS.
- Inserts bubbles on hazard or flush, and holds on downstream stall.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1, id_rs2  in  RA_W  source register indices.
- id_rd  in  RA_W  destination register index.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_use_imm  in  1  B operand = immediate.
- id_gs  in  4  ALU function select.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- exm_rd  in  RA_W  EX/MEM destination index.
- exm_reg_write  in  1  EX/MEM writes a register.
- exm_result  in  XLEN  EX/MEM result.
- wb_rd  in  RA_W  MEM/WB destination index.
- wb_reg_write  in  1  MEM/WB writes a register.
- wb_data  in  XLEN  MEM/WB write data.
- flush  in  1  branch redirect; kill the instruction entering EX.
- hold  in  1  downstream stall; freeze the stage.
- id_stall  out  1  decode must hold its instruction this cycle.
- ex_valid  out  1  EX slot holds a valid instruction.
- ex_A, ex_B  out  XLEN  ALU operands after forwarding.
- ex_gs  out  4  ALU function select.
- ex_rd  out  RA_W  destination index.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control bits.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.

Behaviour:
- Reset: rst is sampled on the clk edge. All stage registers clear to 0: ex_valid=0, ex_gs=0, ex_rd=0, all control bits 0, captured data 0. Combinationally, ex_A=ex_B=ex_store_data=0 and id_stall=0 while held in reset. Reset mid-stall drops the EX instruction.
- Latency: an instruction accepted at edge N appears on the ex_* outputs after edge N, for one cycle unless hold is asserted.
- Stage register contents: rs1, rs2, rd, rs1_data, rs2_data, imm, use_imm, gs, and the control bits.
- Forwarding (combinational, from registered rs1/rs2), per source operand:
  - If exm_reg_write and exm_rd!=0 and exm_rd==rs: take exm_result.
  - Else if wb_reg_write and wb_rd!=0 and wb_rd==rs: take wb_data.
  - Else: take the registered data.
  - Priority: EX/MEM over MEM/WB. Index x0 is never forwarded.
- Operand outputs:
  - ex_A = forwarded rs1.
  - ex_B = id_imm (registered) if use_imm, else forwarded rs2.
  - ex_store_data = forwarded rs2, always.
- load_use = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- id_stall = (load_use | hold) & ~rst.
- Next-state priority per edge: rst > hold > flush > load_use > capture.
  - hold: all stage registers retain their values. flush is ignored; the pipeline controller holds flush until hold drops.
  - flush: ex_valid<=0 and control bits<=0; data regs are don't-care.
  - load_use: bubble. ex_valid<=0, control bits<=0. Decode repeats the instruction next cycle, and the hazard clears after one bubble.
  - capture: stage regs <= id_*, ex_valid<=id_valid. Control bits are gated by id_valid.
- Whenever ex_valid=0: ex_reg_write, ex_mem_read and ex_mem_write are guaranteed 0.
- Arithmetic: pure selection, no width change.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds output bubble_cnt (32 bits), incremented on each load-use bubble edge.
  - Adds output flush_cnt (32 bits), incremented on each flush edge that is not held.
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, RA_W.
  - GS constants: GS_ADD=4'b0000, GS_SUB=4'b1000, GS_SLT=4'b0010, GS_SLTU=4'b0011, GS_AND..GS_XOR=4'b01xx.
- Sub-module forward_unit: combinational. Inputs are rs, reg data and both forward sources; output is the selected value. Instantiated twice (rs1, rs2).

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 -> ex_valid=0, ex_A=0, ex_B=0, id_stall=0; first capture appears 1 cycle after rst deasserts.
- EX/MEM priority: EX rs1=5 with exm_rd=5 (exm_result=0x11) and wb_rd=5 (wb_data=0x22), both writing -> ex_A=0x11. Repeat with exm_reg_write=0 -> ex_A=0x22.
- x0: rs2=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF_FFFF, use_imm=0 -> ex_B = registered rs2_data (0).
- Load-use: EX holds lw x7; ID presents add rs1=7 -> id_stall=1 for exactly 1 cycle, next ex_valid=0 with all control bits 0. Following cycle the add is in EX, and once the load reaches MEM/WB, ex_A=wb_data.
- Flush vs load_use: flush=1 together with a load-use condition -> ex_valid=0 next cycle. With ID_EX_PERF_EN, flush_cnt+1 and bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles with a changing id_* -> ex_* constant, id_stall=1. Then flush with hold=1 -> no effect.
